lsu_mem_ctrl: RTL and testbench
===============================

Name: lsu_mem_ctrl

Overview:
Sequential load/store unit for the MEM stage. Decodes funct3 into access size and signedness, then generates word-aligned bus requests with byte enables and shifted store data. Sign/zero-extends load data, reports misaligned, illegal and timeout errors, and drives a valid/ready handshake between the pipeline and data memory. It generalises the combinational load/store type decode with a multi-cycle bus FSM, split access for misaligned addresses, and a parametrised bus timeout.

Parameters:
ADDR_W, 32, byte-address width; mem_addr_o is always word-aligned (bits [1:0] = 0).
TIMEOUT_CYCLES, 16, cycles an access may wait for mem_ready_i before aborting; 0 disables the timeout.

Ports:
clk_i  input  1  clock, all state updates on rising edge
rst_i  input  1  asynchronous, active-high reset
req_valid_i  input  1  pipeline access request
req_ready_o  output  1  unit idle and able to accept a request
req_is_store_i  input  1  1 = store, 0 = load
funct3_i  input  3  instruction funct3
addr_i  input  ADDR_W  effective byte address
wdata_i  input  32  store data from rs2
mem_valid_o  output  1  bus request valid
mem_ready_i  input  1  bus accepts the request; read data is valid in the same cycle
mem_we_o  output  1  bus write enable
mem_addr_o  output  ADDR_W  word-aligned bus address
mem_be_o  output  4  byte enables
mem_wdata_o  output  32  lane-shifted store data
mem_rdata_i  input  32  bus read data
rsp_valid_o  output  1  one-cycle completion pulse
rsp_rdata_o  output  32  extended load result; 0 for stores and errors
rsp_err_o  output  2  0 = ok, 1 = misaligned, 2 = illegal funct3, 3 = bus timeout
busy_o  output  1  stall request to the pipeline (= !req_ready_o)

Behaviour:
- Reset (asynchronous, any state): FSM goes to IDLE. mem_valid_o, mem_we_o, rsp_valid_o, busy_o = 0. mem_addr_o, mem_be_o, mem_wdata_o, rsp_rdata_o, rsp_err_o = 0. req_ready_o = 1. An in-flight bus request is dropped immediately.
- All outputs are registered except req_ready_o and busy_o, which are decoded from the state.
- States: IDLE, ACC0, ACC1, RESP.
- IDLE: req_ready_o = 1. When req_valid_i is 1, latch all request fields.
  - Legal load funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Legal store funct3: 000 SB, 001 SH, 010 SW.
  - Illegal funct3 -> RESP with err = 2; no bus access.
  - Misaligned means H with addr[0] = 1, or W with addr[1:0] != 0.
  - Misaligned without the optional feature -> RESP with err = 1.
  - Otherwise -> ACC0.
- Byte-enable and data layout:
  - off = addr[1:0].
  - Base mask: B = 0001, H = 0011, W = 1111.
  - be8 = base << off (8 bits). wd64 = {32'b0, wdata} << (8*off).
- ACC0:
  - Drive mem_valid_o = 1, mem_addr_o = {addr[ADDR_W-1:2], 2'b00}, mem_be_o = be8[3:0], mem_wdata_o = wd64[31:0], mem_we_o = is_store.
  - Hold all of these stable until mem_ready_i = 1.
  - On mem_ready_i: capture mem_rdata_i as lo. Go to ACC1 if be8[7:4] != 0, else RESP.
- ACC1:
  - mem_addr_o = previous word address + 4, wrapping modulo 2^ADDR_W.
  - mem_be_o = be8[7:4], mem_wdata_o = wd64[63:32].
  - On mem_ready_i: capture hi, go to RESP.
- mem_valid_o deasserts in the cycle after the accepting handshake.
- Timeout:
  - A counter clears on entry to ACC0/ACC1 and increments each cycle the request is waiting.
  - When it reaches TIMEOUT_CYCLES with no mem_ready_i: deassert mem_valid_o, go to RESP with err = 3.
  - mem_ready_i and the timeout in the same cycle: the handshake wins.
- Load result:
  - r64 = {hi, lo} >> (8*off); hi = 0 when not split.
  - LB / LH sign-extend r64[7:0] / r64[15:0]; LBU / LHU zero-extend; LW takes r64[31:0].
- RESP: rsp_valid_o = 1 for exactly one cycle, then IDLE. A new request can be accepted on the following cycle.
- Latency with mem_ready_i held at 1:
  - Aligned: request accepted cycle N, mem_valid_o in N+1, rsp_valid_o in N+2.
  - Split: rsp_valid_o in N+3.
  - Error detected in IDLE: rsp_valid_o in N+1.
- req_valid_i while not in IDLE is ignored. The requester holds the request until req_ready_o is seen.

Optional Feature:
MISALIGN_SPLIT_EN
- Defined: misaligned H/W accesses are split into two word transactions (ACC0 then ACC1) and complete with err = 0.
- Undefined: ACC1 is never entered; misaligned accesses return err = 1 with no bus activity and rsp_rdata_o = 0.
- Aligned behaviour is identical in both builds.

Test Plan:
- Aligned LW at 0x100 with mem_rdata_i = 0xDEADBEEF and immediate ready -> mem_addr_o = 0x100, be = 1111; rsp_rdata_o = 0xDEADBEEF, err = 0, rsp_valid_o two cycles after acceptance.
- LB at 0x103 with rdata 0x80FF0000 -> be = 1000, rsp_rdata_o = 0xFFFFFF80. LBU at the same address -> 0x00000080.
- SH at 0x202, wdata = 0x1234ABCD -> mem_we_o = 1, addr 0x200, be = 1100, mem_wdata_o = 0xABCD0000.
- SW at 0x301, wdata = 0xAABBCCDD:
  - With MISALIGN_SPLIT_EN: two bus writes, (0x300, be 1110, data 0xBBCCDD00) then (0x304, be 0001, data 0x000000AA), err = 0.
  - Without it: err = 1, no mem_valid_o.
- Load with funct3 = 011 -> err = 2 one cycle after acceptance. LW with mem_ready_i held at 0 and TIMEOUT_CYCLES = 16 -> err = 3 and mem_valid_o dropped after 16 wait cycles.
- Assert rst_i in ACC0 while mem_valid_o = 1 -> mem_valid_o = 0 immediately, req_ready_o = 1, no rsp_valid_o pulse.

Source files
------------

// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: MEM-stage load/store unit.
// Decodes funct3 into size/signedness, issues word-aligned bus requests with
// byte enables and lane-shifted store data, extends load data, and reports
// misaligned / illegal / bus-timeout errors over a valid/ready handshake.
// Build option: define MISALIGN_SPLIT_EN to split misaligned H/W accesses into
// two word transactions; without it such accesses return err = 1 with no bus
// activity.
module lsu_mem_ctrl #(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_is_store_i,
  input  logic [2:0]        funct3_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic              mem_valid_o,
  input  logic              mem_ready_i,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [3:0]        mem_be_o,
  output logic [31:0]       mem_wdata_o,
  input  logic [31:0]       mem_rdata_i,
  output logic              rsp_valid_o,
  output logic [31:0]       rsp_rdata_o,
  output logic [1:0]        rsp_err_o,
  output logic              busy_o
);

  typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_e;
  typedef enum logic [1:0] {ERR_OK, ERR_MISALIGN, ERR_ILLEGAL, ERR_TIMEOUT} err_e;

`ifdef MISALIGN_SPLIT_EN
  localparam bit SPLIT_EN = 1'b1;
`else
  localparam bit SPLIT_EN = 1'b0;
`endif

  localparam bit TO_EN = (TIMEOUT_CYCLES > 0);
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  state_e              state_q, state_d;
  logic                mem_valid_q, mem_valid_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [3:0]          mem_be_q, mem_be_d;
  logic [31:0]         mem_wdata_q, mem_wdata_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [31:0]         rsp_rdata_q, rsp_rdata_d;
  logic [1:0]          rsp_err_q, rsp_err_d;
  logic                is_store_q, is_store_d;
  logic [2:0]          funct3_q, funct3_d;
  logic [1:0]          off_q, off_d;
  logic [3:0]          be_hi_q, be_hi_d;
  logic [31:0]         wd_hi_q, wd_hi_d;
  logic [31:0]         lo_q, lo_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  // Sign/zero extension of the byte-aligned load value according to funct3.
  function automatic logic [31:0] extend(input logic [2:0] f3, input logic [31:0] r);
    case (f3)
      3'b000:  return {{24{r[7]}}, r[7:0]};
      3'b001:  return {{16{r[15]}}, r[15:0]};
      3'b100:  return {24'b0, r[7:0]};
      3'b101:  return {16'b0, r[15:0]};
      default: return r;
    endcase
  endfunction

  // Request decode: legality, alignment, byte-enable and store-data lanes.
  logic        illegal, misaligned;
  logic [3:0]  base_be;
  logic [7:0]  be8;
  logic [63:0] wd64;
  always_comb begin
    illegal    = (funct3_i[1:0] == 2'b11) ||
                 (funct3_i[2] && (req_is_store_i || funct3_i[1]));
    misaligned = (funct3_i[1:0] == 2'b01 && addr_i[0]) ||
                 (funct3_i[1:0] == 2'b10 && addr_i[1:0] != 2'b00);
    case (funct3_i[1:0])
      2'b00:   base_be = 4'b0001;
      2'b01:   base_be = 4'b0011;
      default: base_be = 4'b1111;
    endcase
    be8  = {4'b0000, base_be} << addr_i[1:0];
    wd64 = {32'b0, wdata_i} << {addr_i[1:0], 3'b000};
  end

  // Load result: the word pair shifted down by the byte offset, then extended.
  logic [63:0] pair;
  logic [31:0] load_res;
  always_comb begin
    pair     = (state_q == ACC1) ? {mem_rdata_i, lo_q} : {32'b0, mem_rdata_i};
    load_res = extend(funct3_q, 32'(pair >> {off_q, 3'b000}));
  end

  // Next-state and next-output logic for the bus FSM.
  // NOTE: every _d gets its hold value first so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    mem_valid_d = mem_valid_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    is_store_d  = is_store_q;
    funct3_d    = funct3_q;
    off_d       = off_q;
    be_hi_d     = be_hi_q;
    wd_hi_d     = wd_hi_q;
    lo_d        = lo_q;
    cnt_d       = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          is_store_d  = req_is_store_i;
          funct3_d    = funct3_i;
          off_d       = addr_i[1:0];
          be_hi_d     = be8[7:4];
          wd_hi_d     = wd64[63:32];
          lo_d        = '0;
          rsp_rdata_d = '0;
          rsp_err_d   = ERR_OK;
          if (illegal) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = ERR_ILLEGAL;
          end else if (misaligned && !SPLIT_EN) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = ERR_MISALIGN;
          end else begin
            state_d     = ACC0;
            mem_valid_d = 1'b1;
            mem_we_d    = req_is_store_i;
            mem_addr_d  = {addr_i[ADDR_W-1:2], 2'b00};
            mem_be_d    = be8[3:0];
            mem_wdata_d = wd64[31:0];
            cnt_d       = '0;
          end
        end
      end
      ACC0, ACC1: begin
        if (mem_ready_i) begin
          if (state_q == ACC0 && be_hi_q != 4'b0000) begin
            // Spill into the next word: request stays valid for the second beat.
            state_d     = ACC1;
            lo_d        = mem_rdata_i;
            mem_addr_d  = mem_addr_q + ADDR_W'(4);
            mem_be_d    = be_hi_q;
            mem_wdata_d = wd_hi_q;
            cnt_d       = '0;
          end else begin
            state_d     = RESP;
            mem_valid_d = 1'b0;
            rsp_valid_d = 1'b1;
            rsp_err_d   = ERR_OK;
            rsp_rdata_d = is_store_q ? 32'b0 : load_res;
          end
        end else if (TO_EN && cnt_q == CNT_LAST) begin
          state_d     = RESP;
          mem_valid_d = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = ERR_TIMEOUT;
          rsp_rdata_d = '0;
        end else if (TO_EN) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered-output update; reset drops any in-flight request.
  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      mem_valid_q <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= '0;
      is_store_q  <= 1'b0;
      funct3_q    <= '0;
      off_q       <= '0;
      be_hi_q     <= '0;
      wd_hi_q     <= '0;
      lo_q        <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      mem_valid_q <= mem_valid_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      is_store_q  <= is_store_d;
      funct3_q    <= funct3_d;
      off_q       <= off_d;
      be_hi_q     <= be_hi_d;
      wd_hi_q     <= wd_hi_d;
      lo_q        <= lo_d;
      cnt_q       <= cnt_d;
    end
  end

  assign req_ready_o = (state_q == IDLE);
  assign busy_o      = ~req_ready_o;
  assign mem_valid_o = mem_valid_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_be_o    = mem_be_q;
  assign mem_wdata_o = mem_wdata_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl with response and bus-beat scoreboards.
module tb_lsu_mem_ctrl;
  localparam int AW = 32;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          req_valid_i, req_ready_o, req_is_store_i;
  logic [2:0]    funct3_i;
  logic [AW-1:0] addr_i;
  logic [31:0]   wdata_i;
  logic          mem_valid_o, mem_ready_i, mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [3:0]    mem_be_o;
  logic [31:0]   mem_wdata_o, mem_rdata_i;
  logic          rsp_valid_o;
  logic [31:0]   rsp_rdata_o;
  logic [1:0]    rsp_err_o;
  logic          busy_o;

  lsu_mem_ctrl #(.ADDR_W(AW), .TIMEOUT_CYCLES(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_is_store_i(req_is_store_i), .funct3_i(funct3_i),
    .addr_i(addr_i), .wdata_i(wdata_i),
    .mem_valid_o(mem_valid_o), .mem_ready_i(mem_ready_i), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
    .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {logic [31:0] rdata; logic [1:0] err;} rsp_t;
  typedef struct packed {logic we; logic [31:0] addr; logic [3:0] be; logic [31:0] wdata;} beat_t;

  rsp_t  rsp_q[$];
  beat_t bus_q[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int valid_cycles = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Bus monitor: counts valid cycles and checks every accepted beat.
  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (mem_valid_o) valid_cycles++;
      if (mem_valid_o && mem_ready_i) begin
        check("bus_beat_expected", 32'(bus_q.size() != 0), 32'd1);
        if (bus_q.size() != 0) begin
          beat_t b;
          b = bus_q.pop_front();
          check("bus_we", 32'(mem_we_o), 32'(b.we));
          check("bus_addr", mem_addr_o, b.addr);
          check("bus_be", 32'(mem_be_o), 32'(b.be));
          check("bus_wdata", mem_wdata_o, b.wdata);
        end
      end
    end
  end

  // Response monitor: pops the scoreboard on every completion pulse.
  always @(negedge clk_i) begin
    if (!rst_i && rsp_valid_o) begin
      check("rsp_expected", 32'(rsp_q.size() != 0), 32'd1);
      if (rsp_q.size() != 0) begin
        rsp_t r;
        r = rsp_q.pop_front();
        check("rsp_rdata", rsp_rdata_o, r.rdata);
        check("rsp_err", 32'(rsp_err_o), 32'(r.err));
      end
    end
  end

  task automatic push_rsp(input logic [31:0] rd, input logic [1:0] err);
    rsp_q.push_back('{rdata: rd, err: err});
  endtask

  task automatic push_beat(input logic we, input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd);
    bus_q.push_back('{we: we, addr: a, be: be, wdata: wd});
  endtask

  // Present a request, hold it until req_ready_o, return the accept-edge count.
  task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, output int acc);
    bit ok;
    @(posedge clk_i); #1;
    req_valid_i = 1'b1; req_is_store_i = st; funct3_i = f3; addr_i = a; wdata_i = wd;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk_i);
      if (req_ready_o) begin ok = 1'b1; break; end
    end
    check("req_ready_seen", 32'(ok), 32'd1);
    @(posedge clk_i); #1;
    acc = cyc;
    req_valid_i = 1'b0; req_is_store_i = 1'b0; funct3_i = '0; addr_i = '0; wdata_i = '0;
  endtask

  // Wait (bounded) for the response pulse, check latency and single-cycle width.
  task automatic wait_rsp(input string tag, input int acc, input int lat);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk_i);
      if (rsp_valid_o) begin ok = 1'b1; break; end
    end
    check({tag, "_rsp_seen"}, 32'(ok), 32'd1);
    if (ok) begin
      check({tag, "_latency"}, 32'(cyc - acc), 32'(lat));
      @(negedge clk_i);
      check({tag, "_pulse_width"}, 32'(rsp_valid_o), 32'd0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acc, v0;
    bit seen;
    rst_i = 1'b1; req_valid_i = 1'b0; req_is_store_i = 1'b0; funct3_i = '0;
    addr_i = '0; wdata_i = '0; mem_ready_i = 1'b1; mem_rdata_i = '0;
    #1;
    check("rst_req_ready", 32'(req_ready_o), 32'd1);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_mem_valid", 32'(mem_valid_o), 32'd0);
    check("rst_mem_we", 32'(mem_we_o), 32'd0);
    check("rst_mem_addr", mem_addr_o, 32'd0);
    check("rst_mem_be", 32'(mem_be_o), 32'd0);
    check("rst_mem_wdata", mem_wdata_o, 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
    check("rst_rsp_rdata", rsp_rdata_o, 32'd0);
    check("rst_rsp_err", 32'(rsp_err_o), 32'd0);
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;

    // Aligned LW
    mem_rdata_i = 32'hDEADBEEF;
    push_beat(1'b0, 32'h100, 4'b1111, 32'h0);
    push_rsp(32'hDEADBEEF, 2'd0);
    issue(1'b0, 3'b010, 32'h100, 32'h0, acc);
    wait_rsp("lw_aligned", acc, 1);

    // LB / LBU at byte 3
    mem_rdata_i = 32'h80FF0000;
    push_beat(1'b0, 32'h100, 4'b1000, 32'h0);
    push_rsp(32'hFFFFFF80, 2'd0);
    issue(1'b0, 3'b000, 32'h103, 32'h0, acc);
    wait_rsp("lb", acc, 1);
    push_beat(1'b0, 32'h100, 4'b1000, 32'h0);
    push_rsp(32'h00000080, 2'd0);
    issue(1'b0, 3'b100, 32'h103, 32'h0, acc);
    wait_rsp("lbu", acc, 1);

    // LH / LHU at halfword 2
    mem_rdata_i = 32'h80015555;
    push_beat(1'b0, 32'h204, 4'b1100, 32'h0);
    push_rsp(32'hFFFF8001, 2'd0);
    issue(1'b0, 3'b001, 32'h206, 32'h0, acc);
    wait_rsp("lh", acc, 1);
    push_beat(1'b0, 32'h204, 4'b1100, 32'h0);
    push_rsp(32'h00008001, 2'd0);
    issue(1'b0, 3'b101, 32'h206, 32'h0, acc);
    wait_rsp("lhu", acc, 1);

    // SH at 0x202
    push_beat(1'b1, 32'h200, 4'b1100, 32'hABCD0000);
    push_rsp(32'h0, 2'd0);
    issue(1'b1, 3'b001, 32'h202, 32'h1234ABCD, acc);
    wait_rsp("sh", acc, 1);

    // Misaligned SW and LW
    v0 = valid_cycles;
    mem_rdata_i = 32'h11223344;
`ifdef MISALIGN_SPLIT_EN
    push_beat(1'b1, 32'h300, 4'b1110, 32'hBBCCDD00);
    push_beat(1'b1, 32'h304, 4'b0001, 32'h000000AA);
    push_rsp(32'h0, 2'd0);
    issue(1'b1, 3'b010, 32'h301, 32'hAABBCCDD, acc);
    wait_rsp("sw_split", acc, 2);
    push_beat(1'b0, 32'h100, 4'b1100, 32'h0);
    push_beat(1'b0, 32'h104, 4'b0011, 32'h0);
    push_rsp(32'h33441122, 2'd0);
    issue(1'b0, 3'b010, 32'h102, 32'h0, acc);
    wait_rsp("lw_split", acc, 2);
    check("split_valid_cycles", 32'(valid_cycles - v0), 32'd4);
`else
    push_rsp(32'h0, 2'd1);
    issue(1'b1, 3'b010, 32'h301, 32'hAABBCCDD, acc);
    wait_rsp("sw_misaligned", acc, 0);
    push_rsp(32'h0, 2'd1);
    issue(1'b0, 3'b010, 32'h102, 32'h0, acc);
    wait_rsp("lw_misaligned", acc, 0);
    check("misaligned_no_bus", 32'(valid_cycles - v0), 32'd0);
`endif

    // Illegal funct3 for load and store
    v0 = valid_cycles;
    push_rsp(32'h0, 2'd2);
    issue(1'b0, 3'b011, 32'h100, 32'h0, acc);
    wait_rsp("illegal_load", acc, 0);
    push_rsp(32'h0, 2'd2);
    issue(1'b1, 3'b100, 32'h100, 32'h5, acc);
    wait_rsp("illegal_store", acc, 0);
    check("illegal_no_bus", 32'(valid_cycles - v0), 32'd0);

    // Bus timeout with ready held low
    mem_ready_i = 1'b0;
    v0 = valid_cycles;
    push_rsp(32'h0, 2'd3);
    issue(1'b0, 3'b010, 32'h400, 32'h0, acc);
    wait_rsp("timeout", acc, 16);
    check("timeout_valid_cycles", 32'(valid_cycles - v0), 32'd16);
    check("timeout_valid_dropped", 32'(mem_valid_o), 32'd0);

    // Reset while a request is outstanding in ACC0
    issue(1'b0, 3'b010, 32'h500, 32'h0, acc);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      if (mem_valid_o) begin seen = 1'b1; break; end
    end
    check("acc0_valid_seen", 32'(seen), 32'd1);
    check("acc0_busy", 32'(busy_o), 32'd1);
    check("acc0_req_ready", 32'(req_ready_o), 32'd0);
    #2 rst_i = 1'b1;
    #1;
    check("midrst_mem_valid", 32'(mem_valid_o), 32'd0);
    check("midrst_req_ready", 32'(req_ready_o), 32'd1);
    check("midrst_busy", 32'(busy_o), 32'd0);
    check("midrst_mem_addr", mem_addr_o, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    mem_ready_i = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      if (rsp_valid_o || mem_valid_o) seen = 1'b1;
    end
    check("postrst_quiet", 32'(seen), 32'd0);

    // Recovery: plain aligned store after reset
    push_beat(1'b1, 32'h600, 4'b0100, 32'h00CD0000);
    push_rsp(32'h0, 2'd0);
    issue(1'b1, 3'b000, 32'h602, 32'h000000CD, acc);
    wait_rsp("sb_after_reset", acc, 1);

    check("rsp_q_drained", 32'(rsp_q.size()), 32'd0);
    check("bus_q_drained", 32'(bus_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
